pc060ha_mailbox: RTL and testbench
==================================

Name: pc060ha_mailbox

Overview:
- Nibble mailbox core of the PC060HA sound-communication block. It sits directly downstream of the page register controllers, one each for the main-CPU (master) and sound-CPU (slave) sides.
- It consumes each side's 3-bit page index and provides the following, all synchronous to CLK:
  - four master-to-slave data nibbles and four slave-to-master data nibbles;
  - per-pair "full" handshake flags;
  - a status page;
  - slave NMI generation;
  - sound-CPU reset control.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the nRD/nWR strobe synchronizers on each side. Legal range is 2..3.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- nRESET  in  1  reset; asynchronous, active-low.
- M_nCS  in  1  master chip select, active-low.
- M_nRD  in  1  master read strobe, active-low.
- M_nWR  in  1  master write strobe, active-low.
- M_PAGE  in  3  master page index from the master page register.
- M_DIN  in  4  master write data D0-D3.
- M_DOUT  out  4  master read data.
- S_nCS  in  1  slave chip select, active-low.
- S_nRD  in  1  slave read strobe, active-low.
- S_nWR  in  1  slave write strobe, active-low.
- S_PAGE  in  3  slave page index.
- S_DIN  in  4  slave write data.
- S_DOUT  out  4  slave read data.
- S_nNMI  out  1  slave NMI request, active-low.
- SND_nRESET  out  1  sound-CPU reset, active-low.

Behaviour:
- Reset (asynchronous, while nRESET=0):
  - all mailbox nibbles = 0; m2s_full[1:0] = 0; s2m_full[1:0] = 0; nmi_en = 0;
  - SND_nRESET = 1; M_DOUT = 0; S_DOUT = 0; S_nNMI = 1;
  - synchronizer flops = 1.
- Strobe sync:
  - Each nRD/nWR passes through SYNC_STAGES flops.
  - An access event is the rising edge (deassertion) of the synced strobe, qualified by nCS=0 sampled in the previous cycle.
  - PAGE and DIN are sampled on the event cycle.
  - Events take effect one cycle after detection: latency from raw strobe rise is SYNC_STAGES+1 cycles.
- Master write event, by page:
  - page 0-3: m2s[page] <= M_DIN.
  - page 1 additionally sets m2s_full[0]; page 3 additionally sets m2s_full[1].
  - page 4: SND_nRESET <= ~M_DIN[0]. Bits 3:1 are ignored.
  - pages 5-7: no effect.
- Slave write event, by page:
  - page 0-3: s2m[page] <= S_DIN.
  - page 1 sets s2m_full[0]; page 3 sets s2m_full[1].
  - page 5: nmi_en <= 0. page 6: nmi_en <= 1. pages 4 and 7: no effect.
- Read events (flags clear at the end of the read, so data is stable throughout the strobe):
  - slave read event on page 1 clears m2s_full[0]; on page 3 clears m2s_full[1];
  - master read event on page 1 clears s2m_full[0]; on page 3 clears s2m_full[1];
  - reads of any other page have no side effect.
- Read data (registered, updated every cycle from the current PAGE, so it is valid one cycle after a PAGE change):
  - M_DOUT: pages 0-3 give s2m[page]; page 4 gives {m2s_full[1:0], s2m_full[1:0]}; pages 5-7 give 0.
  - S_DOUT: pages 0-3 give m2s[page]; page 4 gives {s2m_full[1:0], m2s_full[1:0]}; pages 5-7 give 0.
- S_nNMI is registered: S_nNMI <= ~(nmi_en & (m2s_full[0] | m2s_full[1])).
- Boundaries:
  - A set and a clear of the same flag in the same cycle: set wins.
  - Overwriting a full pair: data is replaced and the flag stays 1. There is no overflow indication.
  - Strobes while nCS=1 are ignored.
  - A strobe already low when nRESET releases produces no event until it rises again after being seen low post-reset. Synchronizers reset to 1.
  - Reset asserted mid-access aborts the access; no partial writes occur.
  - SND_nRESET is affected only by nRESET and by master page-4 writes.

Test Plan:
- Master writes page 0=0x3, 1=0xA, then slave reads pages 0,1 -> S_DOUT shows 0x3, then 0xA; m2s_full[0] goes 1 after the write and 0 after the slave read of page 1; master page-4 read shows 0x4, later 0x0.
- Slave writes 6 (nmi_en=1), then master writes page 3 -> S_nNMI=0 within 2 cycles of the flag set; slave reads page 3 -> S_nNMI returns to 1; slave writes 5 and the master rewrites page 3 -> S_nNMI stays 1.
- Master writes page 4 = 0x1 -> SND_nRESET=0; writes 0x0 -> SND_nRESET=1; asserting nRESET forces 1 asynchronously.
- Master write to page 1 and slave read of page 1 land on the same CLK event -> m2s_full[0]=1 and m2s[1] holds the new data.
- Strobe pulses with nCS=1, and writes to pages 5-7 from the master -> no state change; pages 5-7 read 0x0 on both sides.
- nRESET pulsed low mid-write with nWR held low -> all flags and data are 0, no write commits; the next full strobe cycle writes normally.

Source files
------------

// File: rtl/pc060ha_mailbox.sv
// PC060HA nibble mailbox: two 4-entry nibble mailboxes between main and sound CPUs,
// full-flag handshake, status page, slave NMI generation and sound-CPU reset control.

module pc060ha_strobe_sync #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic nRESET,
    input  logic strobe_n_i,
    input  logic cs_n_i,
    output logic event_o
);

    // One extra flop beyond the synchronizer depth holds the previous synced value.
    logic [STAGES:0] sync_q;
    logic            cs_n_q;

    // Strobe synchronizer chain and chip-select sample, all idle-high out of reset
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sync_q <= {(STAGES + 1){1'b1}};
            cs_n_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-1:0], strobe_n_i};
            cs_n_q <= cs_n_i;
        end
    end

    // Access completes on the deasserting edge of the synced strobe.
    assign event_o = sync_q[STAGES-1] & ~sync_q[STAGES] & ~cs_n_q;

endmodule

module pc060ha_mailbox #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       M_nCS,
    input  logic       M_nRD,
    input  logic       M_nWR,
    input  logic [2:0] M_PAGE,
    input  logic [3:0] M_DIN,
    output logic [3:0] M_DOUT,
    input  logic       S_nCS,
    input  logic       S_nRD,
    input  logic       S_nWR,
    input  logic [2:0] S_PAGE,
    input  logic [3:0] S_DIN,
    output logic [3:0] S_DOUT,
    output logic       S_nNMI,
    output logic       SND_nRESET
);

    logic m_wr_ev_s;
    logic m_rd_ev_s;
    logic s_wr_ev_s;
    logic s_rd_ev_s;

    logic [3:0][3:0] m2s_q;
    logic [3:0][3:0] m2s_d;
    logic [3:0][3:0] s2m_q;
    logic [3:0][3:0] s2m_d;
    logic [1:0]      m2s_full_q;
    logic [1:0]      m2s_full_d;
    logic [1:0]      s2m_full_q;
    logic [1:0]      s2m_full_d;
    logic [1:0]      m2s_set_s;
    logic [1:0]      m2s_clr_s;
    logic [1:0]      s2m_set_s;
    logic [1:0]      s2m_clr_s;
    logic            nmi_en_q;
    logic            nmi_en_d;
    logic            snd_nreset_q;
    logic            snd_nreset_d;
    logic            s_nnmi_q;
    logic            s_nnmi_d;
    logic [3:0]      m_dout_q;
    logic [3:0]      m_dout_d;
    logic [3:0]      s_dout_q;
    logic [3:0]      s_dout_d;

    pc060ha_strobe_sync #(.STAGES(SYNC_STAGES)) u_m_wr_sync (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .strobe_n_i (M_nWR),
        .cs_n_i     (M_nCS),
        .event_o    (m_wr_ev_s)
    );

    pc060ha_strobe_sync #(.STAGES(SYNC_STAGES)) u_m_rd_sync (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .strobe_n_i (M_nRD),
        .cs_n_i     (M_nCS),
        .event_o    (m_rd_ev_s)
    );

    pc060ha_strobe_sync #(.STAGES(SYNC_STAGES)) u_s_wr_sync (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .strobe_n_i (S_nWR),
        .cs_n_i     (S_nCS),
        .event_o    (s_wr_ev_s)
    );

    pc060ha_strobe_sync #(.STAGES(SYNC_STAGES)) u_s_rd_sync (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .strobe_n_i (S_nRD),
        .cs_n_i     (S_nCS),
        .event_o    (s_rd_ev_s)
    );

    function automatic logic [3:0] rd_mux(
        input logic [2:0]      page,
        input logic [3:0][3:0] mbox,
        input logic [3:0]      status
    );
        logic [3:0] res;
        case (page)
            3'd0, 3'd1, 3'd2, 3'd3: res = mbox[page[1:0]];
            3'd4:                   res = status;
            default:                res = 4'h0;
        endcase
        return res;
    endfunction

    // Pages 1 and 3 carry the handshake for data pairs {0,1} and {2,3}.
    assign m2s_set_s = {m_wr_ev_s & (M_PAGE == 3'd3), m_wr_ev_s & (M_PAGE == 3'd1)};
    assign m2s_clr_s = {s_rd_ev_s & (S_PAGE == 3'd3), s_rd_ev_s & (S_PAGE == 3'd1)};
    assign s2m_set_s = {s_wr_ev_s & (S_PAGE == 3'd3), s_wr_ev_s & (S_PAGE == 3'd1)};
    assign s2m_clr_s = {m_rd_ev_s & (M_PAGE == 3'd3), m_rd_ev_s & (M_PAGE == 3'd1)};

    // Master write decode: mailbox data and sound-CPU reset control
    always_comb begin
        m2s_d        = m2s_q;
        snd_nreset_d = snd_nreset_q;
        if (m_wr_ev_s) begin
            case (M_PAGE)
                3'd0, 3'd1, 3'd2, 3'd3: m2s_d[M_PAGE[1:0]] = M_DIN;
                3'd4:                   snd_nreset_d = ~M_DIN[0];
                default:                m2s_d = m2s_q;
            endcase
        end else begin
            m2s_d = m2s_q;
        end
    end

    // Slave write decode: mailbox data and NMI enable
    always_comb begin
        s2m_d    = s2m_q;
        nmi_en_d = nmi_en_q;
        if (s_wr_ev_s) begin
            case (S_PAGE)
                3'd0, 3'd1, 3'd2, 3'd3: s2m_d[S_PAGE[1:0]] = S_DIN;
                3'd5:                   nmi_en_d = 1'b0;
                3'd6:                   nmi_en_d = 1'b1;
                default:                s2m_d = s2m_q;
            endcase
        end else begin
            s2m_d = s2m_q;
        end
    end

    // Flag update (set has priority over clear), read muxes and NMI request
    always_comb begin
        m2s_full_d = (m2s_full_q & ~m2s_clr_s) | m2s_set_s;
        s2m_full_d = (s2m_full_q & ~s2m_clr_s) | s2m_set_s;
        m_dout_d   = rd_mux(M_PAGE, s2m_q, {m2s_full_q, s2m_full_q});
        s_dout_d   = rd_mux(S_PAGE, m2s_q, {s2m_full_q, m2s_full_q});
        s_nnmi_d   = ~(nmi_en_q & (m2s_full_q[0] | m2s_full_q[1]));
    end

    // Mailbox state and registered outputs
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            m2s_q        <= {4{4'h0}};
            s2m_q        <= {4{4'h0}};
            m2s_full_q   <= 2'b00;
            s2m_full_q   <= 2'b00;
            nmi_en_q     <= 1'b0;
            snd_nreset_q <= 1'b1;
            s_nnmi_q     <= 1'b1;
            m_dout_q     <= 4'h0;
            s_dout_q     <= 4'h0;
        end else begin
            m2s_q        <= m2s_d;
            s2m_q        <= s2m_d;
            m2s_full_q   <= m2s_full_d;
            s2m_full_q   <= s2m_full_d;
            nmi_en_q     <= nmi_en_d;
            snd_nreset_q <= snd_nreset_d;
            s_nnmi_q     <= s_nnmi_d;
            m_dout_q     <= m_dout_d;
            s_dout_q     <= s_dout_d;
        end
    end

    assign M_DOUT     = m_dout_q;
    assign S_DOUT     = s_dout_q;
    assign S_nNMI     = s_nnmi_q;
    assign SND_nRESET = snd_nreset_q;

endmodule

// File: tb/tb_pc060ha_mailbox.sv
// Scoreboard bench for pc060ha_mailbox: stimulus queues expectations, a
// negedge monitor pops and compares them against the selected DUT output.

module tb_pc060ha_mailbox;

    localparam int SYNC = 2;

    logic       CLK = 1'b0;
    logic       nRESET;
    logic       M_nCS, M_nRD, M_nWR;
    logic [2:0] M_PAGE;
    logic [3:0] M_DIN;
    logic [3:0] M_DOUT;
    logic       S_nCS, S_nRD, S_nWR;
    logic [2:0] S_PAGE;
    logic [3:0] S_DIN;
    logic [3:0] S_DOUT;
    logic       S_nNMI;
    logic       SND_nRESET;

    pc060ha_mailbox #(.SYNC_STAGES(SYNC)) dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .M_nCS      (M_nCS),
        .M_nRD      (M_nRD),
        .M_nWR      (M_nWR),
        .M_PAGE     (M_PAGE),
        .M_DIN      (M_DIN),
        .M_DOUT     (M_DOUT),
        .S_nCS      (S_nCS),
        .S_nRD      (S_nRD),
        .S_nWR      (S_nWR),
        .S_PAGE     (S_PAGE),
        .S_DIN      (S_DIN),
        .S_DOUT     (S_DOUT),
        .S_nNMI     (S_nNMI),
        .SND_nRESET (SND_nRESET)
    );

    always #5 CLK = ~CLK;

    localparam int SEL_MDOUT = 0;
    localparam int SEL_SDOUT = 1;
    localparam int SEL_NMI   = 2;
    localparam int SEL_SNDR  = 3;

    string      name_q[$];
    int         sel_q[$];
    logic [3:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // Monitor: compare every queued expectation at the falling edge.
    always @(negedge CLK) begin
        while (exp_q.size() > 0) begin
            string      nm;
            int         sel;
            logic [3:0] ex;
            logic [3:0] act;
            nm  = name_q.pop_front();
            sel = sel_q.pop_front();
            ex  = exp_q.pop_front();
            case (sel)
                SEL_MDOUT: act = M_DOUT;
                SEL_SDOUT: act = S_DOUT;
                SEL_NMI:   act = {3'b000, S_nNMI};
                SEL_SNDR:  act = {3'b000, SND_nRESET};
                default:   act = 4'hx;
            endcase
            n_cmp = n_cmp + 1;
            if (act !== ex) begin
                n_bad = n_bad + 1;
                $display("FAIL %s: got %h expected %h at %0t", nm, act, ex, $time);
            end
        end
    end

    // Watchdog: flag a hung simulation if the stimulus never completes.
    initial begin
        #200000;
        n_bad = n_bad + 1;
        $display("FAIL watchdog: wait expired, simulation did not finish at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic push(input string nm, input int sel, input logic [3:0] ex);
        name_q.push_back(nm);
        sel_q.push_back(sel);
        exp_q.push_back(ex);
    endtask

    task automatic m_acc(input logic wr, input logic cs_n, input logic [2:0] page, input logic [3:0] din);
        @(posedge CLK); #1;
        M_PAGE = page; M_DIN = din; M_nCS = cs_n;
        @(posedge CLK); #1;
        if (wr) M_nWR = 1'b0; else M_nRD = 1'b0;
        repeat (SYNC + 2) @(posedge CLK);
        #1;
        M_nWR = 1'b1; M_nRD = 1'b1;
        repeat (SYNC + 3) @(posedge CLK);
        #1;
        M_nCS = 1'b1;
    endtask

    task automatic s_acc(input logic wr, input logic cs_n, input logic [2:0] page, input logic [3:0] din);
        @(posedge CLK); #1;
        S_PAGE = page; S_DIN = din; S_nCS = cs_n;
        @(posedge CLK); #1;
        if (wr) S_nWR = 1'b0; else S_nRD = 1'b0;
        repeat (SYNC + 2) @(posedge CLK);
        #1;
        S_nWR = 1'b1; S_nRD = 1'b1;
        repeat (SYNC + 3) @(posedge CLK);
        #1;
        S_nCS = 1'b1;
    endtask

    task automatic m_chk(input string nm, input logic [2:0] page, input logic [3:0] ex);
        @(posedge CLK); #1;
        M_PAGE = page;
        repeat (2) @(posedge CLK);
        #1;
        push(nm, SEL_MDOUT, ex);
    endtask

    task automatic s_chk(input string nm, input logic [2:0] page, input logic [3:0] ex);
        @(posedge CLK); #1;
        S_PAGE = page;
        repeat (2) @(posedge CLK);
        #1;
        push(nm, SEL_SDOUT, ex);
    endtask

    task automatic sig_chk(input string nm, input int sel, input logic [3:0] ex);
        @(posedge CLK); #1;
        push(nm, sel, ex);
    endtask

    initial begin
        nRESET = 1'b0;
        M_nCS = 1'b1; M_nRD = 1'b1; M_nWR = 1'b1; M_PAGE = 3'd0; M_DIN = 4'h0;
        S_nCS = 1'b1; S_nRD = 1'b1; S_nWR = 1'b1; S_PAGE = 3'd0; S_DIN = 4'h0;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp = n_cmp + 1;
        if (M_DOUT !== 4'h0 || S_DOUT !== 4'h0 || S_nNMI !== 1'b1 || SND_nRESET !== 1'b1) begin
            n_bad = n_bad + 1;
            $display("FAIL reset_state: M_DOUT=%h S_DOUT=%h S_nNMI=%b SND_nRESET=%b at %0t",
                     M_DOUT, S_DOUT, S_nNMI, SND_nRESET, $time);
        end
        push("rst_mdout", SEL_MDOUT, 4'h0);
        push("rst_sdout", SEL_SDOUT, 4'h0);
        push("rst_nmi",   SEL_NMI,   4'h1);
        push("rst_sndr",  SEL_SNDR,  4'h1);
        @(posedge CLK); #1;
        nRESET = 1'b1;

        // Master -> slave data and full-flag handshake
        m_acc(1'b1, 1'b0, 3'd0, 4'h3);
        m_acc(1'b1, 1'b0, 3'd1, 4'hA);
        s_chk("s_rd_p0", 3'd0, 4'h3);
        s_chk("s_rd_p1", 3'd1, 4'hA);
        m_chk("m_stat_full0", 3'd4, 4'h4);
        sig_chk("nmi_disabled", SEL_NMI, 4'h1);
        s_acc(1'b0, 1'b0, 3'd1, 4'h0);
        m_chk("m_stat_clr0", 3'd4, 4'h0);
        s_chk("s_stat_clr0", 3'd4, 4'h0);

        // NMI enable, trigger and clear
        s_acc(1'b1, 1'b0, 3'd6, 4'h0);
        m_acc(1'b1, 1'b0, 3'd3, 4'h5);
        sig_chk("nmi_asserted", SEL_NMI, 4'h0);
        m_chk("m_stat_full1", 3'd4, 4'h8);
        s_acc(1'b0, 1'b0, 3'd3, 4'h0);
        sig_chk("nmi_released", SEL_NMI, 4'h1);
        s_acc(1'b1, 1'b0, 3'd5, 4'h0);
        m_acc(1'b1, 1'b0, 3'd3, 4'h6);
        sig_chk("nmi_masked", SEL_NMI, 4'h1);
        s_chk("s_rd_p3", 3'd3, 4'h6);
        s_chk("s_stat_full1", 3'd4, 4'h2);
        s_acc(1'b0, 1'b0, 3'd3, 4'h0);
        s_chk("s_stat_clr1", 3'd4, 4'h0);

        // Slave -> master data path
        s_acc(1'b1, 1'b0, 3'd0, 4'h9);
        s_acc(1'b1, 1'b0, 3'd3, 4'hC);
        m_chk("m_rd_p0", 3'd0, 4'h9);
        m_chk("m_rd_p3", 3'd3, 4'hC);
        m_chk("m_stat_s2m1", 3'd4, 4'h2);
        s_chk("s_stat_s2m1", 3'd4, 4'h8);
        m_acc(1'b0, 1'b0, 3'd3, 4'h0);
        m_chk("m_stat_s2m_clr", 3'd4, 4'h0);

        // Sound-CPU reset control and asynchronous reset override
        m_acc(1'b1, 1'b0, 3'd4, 4'h1);
        sig_chk("sndr_assert", SEL_SNDR, 4'h0);
        m_acc(1'b1, 1'b0, 3'd4, 4'hE);
        sig_chk("sndr_release", SEL_SNDR, 4'h1);
        m_acc(1'b1, 1'b0, 3'd4, 4'h1);
        sig_chk("sndr_assert2", SEL_SNDR, 4'h0);
        @(posedge CLK); #1;
        nRESET = 1'b0;
        push("sndr_async_rst", SEL_SNDR, 4'h1);
        repeat (2) @(posedge CLK);
        #1;
        nRESET = 1'b1;
        m_chk("m_rd_p0_after_rst", 3'd0, 4'h0);

        // Same-cycle set (master write) and clear (slave read) of m2s_full[0]
        m_acc(1'b1, 1'b0, 3'd1, 4'h2);
        fork
            m_acc(1'b1, 1'b0, 3'd1, 4'h7);
            s_acc(1'b0, 1'b0, 3'd1, 4'h0);
        join
        s_chk("collide_data", 3'd1, 4'h7);
        s_chk("collide_flag", 3'd4, 4'h1);
        s_acc(1'b0, 1'b0, 3'd1, 4'h0);
        s_chk("collide_clr", 3'd4, 4'h0);

        // Deselected strobes and writes to unused pages
        m_acc(1'b1, 1'b1, 3'd0, 4'hF);
        s_chk("ncs_ignored", 3'd0, 4'h0);
        m_acc(1'b1, 1'b0, 3'd5, 4'hF);
        m_acc(1'b1, 1'b0, 3'd6, 4'hF);
        m_acc(1'b1, 1'b0, 3'd7, 4'hF);
        s_chk("unused_p1", 3'd1, 4'h7);
        s_chk("unused_stat", 3'd4, 4'h0);
        sig_chk("unused_sndr", SEL_SNDR, 4'h1);
        for (int p = 5; p < 8; p++) begin
            m_chk("m_rd_hi_page", p[2:0], 4'h0);
            s_chk("s_rd_hi_page", p[2:0], 4'h0);
        end

        // Reset pulsed mid-write with the strobe held low
        @(posedge CLK); #1;
        M_PAGE = 3'd2; M_DIN = 4'h5; M_nCS = 1'b0;
        @(posedge CLK); #1;
        M_nWR = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        nRESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRESET = 1'b1;
        s_chk("abort_p2", 3'd2, 4'h0);
        s_chk("abort_p1", 3'd1, 4'h0);
        @(posedge CLK); #1;
        M_nCS = 1'b1;
        @(posedge CLK); #1;
        M_nWR = 1'b1;
        repeat (SYNC + 4) @(posedge CLK);
        s_chk("abort_no_commit", 3'd2, 4'h0);
        m_acc(1'b1, 1'b0, 3'd2, 4'h5);
        s_chk("post_abort_write", 3'd2, 4'h5);

        repeat (2) @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
